// File: rtl/dense_argmax_pkg.sv
// Shared definitions for the dense_argmax classifier stage: default sizes and FSM state encodings.
package dense_argmax_pkg;

  localparam int DEF_CLASS_COUNT = 10;
  localparam int DEF_DATA_SIZE   = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/dense_argmax_buf.sv
// Score buffer for dense_argmax: one write port, registered read with one-cycle latency.
// Compiled only when DENSE_ARGMAX_SCORE_BUF_EN is defined.
`ifdef DENSE_ARGMAX_SCORE_BUF_EN
module dense_argmax_buf
  import dense_argmax_pkg::*;
#(
  parameter int DEPTH  = DEF_CLASS_COUNT,
  parameter int DATA_W = DEF_DATA_SIZE,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_wadr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_radr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic              w_rd_in_range;

  assign w_rd_in_range = {1'b0, i_radr} < (ADDR_W + 1)'(DEPTH);
  assign o_rdata       = r_rdata;

  // Storage is not reset: contents survive until the next frame overwrites them.
  always_ff @(posedge clk) begin
    if (i_wr) r_mem[i_wadr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) r_rdata <= '0;
    else     r_rdata <= w_rd_in_range ? r_mem[i_radr] : '0;
  end

endmodule
`endif

// File: rtl/dense_argmax.sv
// Argmax over one frame of CLASS_COUNT signed scores from the Dense layer; reports index, score and a done pulse.
// Optional score buffer readback enabled by defining DENSE_ARGMAX_SCORE_BUF_EN.
module dense_argmax
  import dense_argmax_pkg::*;
#(
  parameter  int CLASS_COUNT = DEF_CLASS_COUNT,
  parameter  int DATA_SIZE   = DEF_DATA_SIZE,
  localparam int IDX_W       = (CLASS_COUNT > 1) ? $clog2(CLASS_COUNT) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        dataValid,
  input  logic signed [DATA_SIZE-1:0] dataIn,
  output logic                        busy,
  output logic                        done,
  output logic        [IDX_W-1:0]     classIdx,
  output logic signed [DATA_SIZE-1:0] maxScore,
  input  logic        [IDX_W-1:0]     scoreAdr,
  output logic        [DATA_SIZE-1:0] scoreData
);

  state_t                      r_state;
  logic        [IDX_W-1:0]     r_count;
  logic        [IDX_W-1:0]     r_run_idx;
  logic signed [DATA_SIZE-1:0] r_run_max;
  logic                        r_busy;
  logic                        r_done;
  logic        [IDX_W-1:0]     r_class_idx;
  logic signed [DATA_SIZE-1:0] r_max_score;

  logic                        w_accept;
  logic                        w_take;
  logic                        w_last;
  logic        [IDX_W-1:0]     w_sel_idx;
  logic signed [DATA_SIZE-1:0] w_sel_max;

  // Strict comparison: on a tie the earlier (lower) index keeps the win.
  function automatic logic f_beats(input logic signed [DATA_SIZE-1:0] a,
                                   input logic signed [DATA_SIZE-1:0] b);
    return a > b;
  endfunction

  assign w_accept  = (r_state == ST_COLLECT) && dataValid;
  assign w_take    = (r_count == '0) || f_beats(dataIn, r_run_max);
  assign w_last    = (r_count == IDX_W'(CLASS_COUNT - 1));
  assign w_sel_idx = w_take ? r_count : r_run_idx;
  assign w_sel_max = w_take ? dataIn  : r_run_max;

  assign busy     = r_busy;
  assign done     = r_done;
  assign classIdx = r_class_idx;
  assign maxScore = r_max_score;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_count     <= '0;
      r_run_idx   <= '0;
      r_run_max   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_class_idx <= '0;
      r_max_score <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_count <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (w_accept) begin
            r_run_idx <= w_sel_idx;
            r_run_max <= w_sel_max;
            r_count   <= r_count + 1'b1;
            // The final sample publishes the result on the same edge that raises done.
            if (w_last) begin
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_class_idx <= w_sel_idx;
              r_max_score <= w_sel_max;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef DENSE_ARGMAX_SCORE_BUF_EN
  dense_argmax_buf #(
    .DEPTH  (CLASS_COUNT),
    .DATA_W (DATA_SIZE),
    .ADDR_W (IDX_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_wr    (w_accept),
    .i_wadr  (r_count),
    .i_wdata (dataIn),
    .i_radr  (scoreAdr),
    .o_rdata (scoreData)
  );
`else
  logic w_unused_adr;
  assign w_unused_adr = ^scoreAdr;
  assign scoreData    = '0;
`endif

endmodule

// File: tb/tb_dense_argmax.sv
// Self-checking bench for dense_argmax: frame-level argmax reference model plus literal pins.
module tb_dense_argmax;

  localparam int CC = 10;
  localparam int DW = 16;
  localparam int IW = 4;
`ifdef DENSE_ARGMAX_SCORE_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, dataValid;
  logic [DW-1:0] dataIn;
  logic          busy, done;
  logic [IW-1:0] classIdx, scoreAdr;
  logic [DW-1:0] maxScore, scoreData;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dense_argmax #(.CLASS_COUNT(CC), .DATA_SIZE(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dataValid (dataValid),
    .dataIn    (dataIn),
    .busy      (busy),
    .done      (done),
    .classIdx  (classIdx),
    .maxScore  (maxScore),
    .scoreAdr  (scoreAdr),
    .scoreData (scoreData)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: collects accepted samples and resolves the winner once the frame is full.
  bit            m_started = 1'b0;
  bit            m_collect = 1'b0;
  bit            m_busy = 1'b0, m_done = 1'b0;
  logic [IW-1:0] m_idx = '0;
  logic [DW-1:0] m_max = '0, m_sd = '0;
  bit            m_sd_known = 1'b0;
  logic [DW-1:0] m_buf [CC];
  bit            m_bvalid [CC];
  int            q[$];

  always @(posedge clk) begin
    bit was_done;
    int best;
    was_done = m_done;
    if (rst) begin
      m_started  = 1'b1;
      m_collect  = 1'b0;
      m_busy     = 1'b0;
      m_done     = 1'b0;
      m_idx      = '0;
      m_max      = '0;
      m_sd       = '0;
      m_sd_known = 1'b1;
      q.delete();
    end else begin
      if (!BUF_EN || scoreAdr >= IW'(CC)) begin
        m_sd = '0;
        m_sd_known = 1'b1;
      end else if (m_bvalid[scoreAdr]) begin
        m_sd = m_buf[scoreAdr];
        m_sd_known = 1'b1;
      end else begin
        m_sd_known = 1'b0;
      end
      m_done = 1'b0;
      if (m_collect) begin
        if (dataValid) begin
          m_buf[q.size()]    = dataIn;
          m_bvalid[q.size()] = 1'b1;
          q.push_back(int'($signed(dataIn)));
          if (q.size() == CC) begin
            best = 0;
            for (int i = 1; i < CC; i++) if (q[i] > q[best]) best = i;
            m_idx     = IW'(best);
            m_max     = DW'(q[best]);
            m_done    = 1'b1;
            m_busy    = 1'b0;
            m_collect = 1'b0;
            q.delete();
          end
        end
      end else if (!was_done && start) begin
        m_collect = 1'b1;
        m_busy    = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("classIdx", 32'(classIdx), 32'(m_idx));
      chk("maxScore", 32'(maxScore), 32'(m_max));
      if (m_sd_known) chk("scoreData", 32'(scoreData), 32'(m_sd));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // gapmode: 0 back-to-back, 1 every other cycle, 2 random gaps; noise toggles start during gaps.
  task automatic run_frame(input logic [DW-1:0] v [CC], input int gapmode, input bit noise);
    int gaps;
    start = 1'b1;
    if (noise) begin
      dataValid = 1'b1;
      dataIn    = DW'($urandom);
    end
    step();
    start     = 1'b0;
    dataValid = 1'b0;
    for (int i = 0; i < CC; i++) begin
      gaps = (gapmode == 0) ? 0 : (gapmode == 1) ? 1 : int'($urandom_range(0, 2));
      repeat (gaps) begin
        dataValid = 1'b0;
        if (noise) start = 1'($urandom);
        dataIn = DW'($urandom);
        step();
      end
      start     = 1'b0;
      dataValid = 1'b1;
      dataIn    = v[i];
      step();
    end
    dataValid = 1'b0;
    start     = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] fr [CC];
    rst = 1'b1; start = 1'b0; dataValid = 1'b0; dataIn = '0; scoreAdr = '0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_idx", 32'(classIdx), 32'd0);
    chk("rst_max", 32'(maxScore), 32'd0);
    chk("rst_sd", 32'(scoreData), 32'd0);
    rst = 1'b0;
    step();

    // 1: ascending scores back-to-back
    for (int i = 0; i < CC; i++) fr[i] = DW'(i);
    run_frame(fr, 0, 1'b0);
    chk("t1_done_lat", 32'(done), 32'd1);
    chk("t1_idx", 32'(classIdx), 32'd9);
    chk("t1_max", 32'(maxScore), 32'h0009);
    step();
    chk("t1_done_pulse", 32'(done), 32'd0);

    // 2: all negative, -1 at index 3
    for (int i = 0; i < CC; i++) fr[i] = DW'(-2 - i);
    fr[3] = 16'hFFFF;
    run_frame(fr, 0, 1'b0);
    chk("t2_idx", 32'(classIdx), 32'd3);
    chk("t2_max", 32'(maxScore), 32'h0000FFFF);
    step();

    // 3: tie between index 2 and 6
    for (int i = 0; i < CC; i++) fr[i] = '0;
    fr[2] = 16'd7;
    fr[6] = 16'd7;
    run_frame(fr, 0, 1'b0);
    chk("t3_idx", 32'(classIdx), 32'd2);
    chk("t3_max", 32'(maxScore), 32'd7);
    step();

    // 4: ascending scores with a gap before every sample
    for (int i = 0; i < CC; i++) fr[i] = DW'(i);
    run_frame(fr, 1, 1'b0);
    chk("t4_idx", 32'(classIdx), 32'd9);
    step();

    // 5: reset after five samples, then a full frame
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dataValid = 1'b1;
      dataIn    = DW'(100 + i);
      step();
    end
    dataValid = 1'b0;
    rst = 1'b1;
    step();
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_idx", 32'(classIdx), 32'd0);
    chk("t5_max", 32'(maxScore), 32'd0);
    rst = 1'b0;
    step();
    fr = '{16'd3, 16'd1, 16'd4, 16'd1, 16'd5, 16'd9, 16'd2, 16'd6, 16'd5, 16'd3};
    run_frame(fr, 0, 1'b0);
    chk("t5b_idx", 32'(classIdx), 32'd5);
    chk("t5b_max", 32'(maxScore), 32'd9);
    // start during the done cycle must be ignored
    start = 1'b1;
    dataValid = 1'b1;
    step();
    start = 1'b0;
    dataValid = 1'b0;
    chk("t5_start_in_done", 32'(busy), 32'd0);

    // 6: buffer readback of the fifth sample
    scoreAdr = 4'd4;
    step();
    chk("t6_sd", 32'(scoreData), BUF_EN ? 32'd5 : 32'd0);
    step();

    // Random frames with idle junk, start noise and random gaps
    for (int f = 0; f < 15; f++) begin
      repeat (2) begin
        dataValid = 1'($urandom);
        dataIn    = DW'($urandom);
        scoreAdr  = IW'($urandom_range(0, CC - 1));
        step();
      end
      dataValid = 1'b0;
      for (int i = 0; i < CC; i++)
        fr[i] = (f % 2 == 0) ? DW'($urandom) : DW'(int'($urandom_range(0, 8)) - 4);
      run_frame(fr, f % 3, 1'b1);
      step();
    end

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
